// File: rtl/vga_sprite_pixel_pipeline.sv
// Overlays one palettised 16x16 sprite on a solid background behind the VGA timing generator.
// Latency: 2 pixel periods from sample to RGB; sync/blank are delayed identically. No backpressure.
module vga_sprite_pixel_pipeline #(
    parameter int          SPR_W    = 16,
    parameter int          SPR_H    = 16,
    parameter int          ADDR_W   = 8,
    parameter logic [23:0] BG_COLOR = 24'h5C94FC
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              pixel_clk,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              hs_in,
    input  logic              vs_in,
    input  logic              blank_in,
    input  logic [9:0]        SpriteX,
    input  logic [9:0]        SpriteY,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [3:0]        rom_data,
    input  logic              pal_we,
    input  logic [3:0]        pal_idx,
    input  logic [23:0]       pal_data,
    output logic [7:0]        VGA_R,
    output logic [7:0]        VGA_G,
    output logic [7:0]        VGA_B,
    output logic              VGA_HS,
    output logic              VGA_VS,
    output logic              VGA_BLANK_N,
    output logic              frame_start
);

    logic              pclk_q;
    logic              pe;
    logic [9:0]        dx;
    logic [9:0]        dy;
    logic              hit0;
    logic [ADDR_W-1:0] lin_addr;

    logic              hs0, vs0, blank0, hit0_q;
    logic              hs1, vs1, blank1, sel1;
    logic [3:0]        idx1;
    logic              vs_hist;
    logic              started;
    logic [23:0]       pal [16];

    assign pe = pixel_clk & ~pclk_q;
    assign dx = DrawX - SpriteX;
    assign dy = DrawY - SpriteY;

    // The explicit ordering test stops a sprite near the right/bottom edge wrapping onto the left/top.
    assign hit0 = (DrawX >= SpriteX) && (DrawY >= SpriteY) &&
                  (dx < 10'(SPR_W)) && (dy < 10'(SPR_H));
    assign lin_addr = ADDR_W'(dy) * ADDR_W'(SPR_W) + ADDR_W'(dx);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pclk_q      <= 1'b0;
            rom_addr    <= '0;
            hs0         <= 1'b0;
            vs0         <= 1'b0;
            blank0      <= 1'b0;
            hit0_q      <= 1'b0;
            hs1         <= 1'b0;
            vs1         <= 1'b0;
            blank1      <= 1'b0;
            sel1        <= 1'b0;
            idx1        <= 4'd0;
            VGA_R       <= 8'd0;
            VGA_G       <= 8'd0;
            VGA_B       <= 8'd0;
            VGA_HS      <= 1'b0;
            VGA_VS      <= 1'b0;
            VGA_BLANK_N <= 1'b0;
            frame_start <= 1'b0;
            vs_hist     <= 1'b1;
            started     <= 1'b0;
            for (int i = 0; i < 16; i++) pal[i] <= 24'h0;
        end else begin
            pclk_q      <= pixel_clk;
            frame_start <= 1'b0;
            if (pal_we) pal[pal_idx] <= pal_data;
            if (pe) begin
                rom_addr <= hit0 ? lin_addr : '0;
                hs0      <= hs_in;
                vs0      <= vs_in;
                blank0   <= blank_in;
                hit0_q   <= hit0;

                // rom_data has been stable since one Clk after rom_addr was issued.
                sel1   <= hit0_q && (rom_data != 4'd0);
                idx1   <= rom_data;
                hs1    <= hs0;
                vs1    <= vs0;
                blank1 <= blank0;

                // A same-cycle palette write is not yet visible to this read.
                if (!blank1)   {VGA_R, VGA_G, VGA_B} <= 24'h0;
                else if (sel1) {VGA_R, VGA_G, VGA_B} <= pal[idx1];
                else           {VGA_R, VGA_G, VGA_B} <= BG_COLOR;
                VGA_HS      <= hs1;
                VGA_VS      <= vs1;
                VGA_BLANK_N <= blank1;

                frame_start <= started && vs_hist && !vs_in;
                vs_hist     <= vs_in;
                started     <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vga_sprite_pixel_pipeline.sv
// Scoreboarded bench: pixels are pushed as they are driven and compared two pixel periods later.
module tb_vga_sprite_pixel_pipeline;

    localparam logic [23:0] BG = 24'h5C94FC;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        pixel_clk = 1'b0;
    logic [9:0]  DrawX = '0, DrawY = '0, SpriteX = '0, SpriteY = '0;
    logic        hs_in = 1'b1, vs_in = 1'b1, blank_in = 1'b0;
    logic [7:0]  rom_addr;
    logic [3:0]  rom_data = 4'd0;
    logic        pal_we = 1'b0;
    logic [3:0]  pal_idx = 4'd0;
    logic [23:0] pal_data = 24'd0;
    logic [7:0]  VGA_R, VGA_G, VGA_B;
    logic        VGA_HS, VGA_VS, VGA_BLANK_N, frame_start;

    vga_sprite_pixel_pipeline dut (
        .Clk(Clk), .Reset(Reset), .pixel_clk(pixel_clk),
        .DrawX(DrawX), .DrawY(DrawY), .hs_in(hs_in), .vs_in(vs_in), .blank_in(blank_in),
        .SpriteX(SpriteX), .SpriteY(SpriteY), .rom_addr(rom_addr), .rom_data(rom_data),
        .pal_we(pal_we), .pal_idx(pal_idx), .pal_data(pal_data),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
        .VGA_BLANK_N(VGA_BLANK_N), .frame_start(frame_start)
    );

    initial forever #5 Clk = ~Clk;

    typedef struct packed {
        logic       hit;
        logic [3:0] idx;
        logic       blank;
        logic       hs;
        logic       vs;
    } desc_t;

    desc_t       sb[$];
    logic [23:0] pal_m [16];
    int          zero_addr = -1;
    int          sx = 0, sy = 0;
    logic        vs_hist_m = 1'b1;
    logic        started_m = 1'b0;
    int          checks = 0, errors = 0;
    int          fs_count = 0, hs_low = 0;

    // Synchronous sprite ROM: index 3 everywhere except an optional transparent address.
    function automatic logic [3:0] rom_fn(input logic [7:0] a);
        return (int'(a) == zero_addr) ? 4'd0 : 4'd3;
    endfunction

    always @(posedge Clk) rom_data <= rom_fn(rom_addr);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [23:0] exp_rgb(input desc_t d);
        if (!d.blank) return 24'h0;
        if (d.hit && d.idx != 4'd0) return pal_m[d.idx];
        return BG;
    endfunction

    task automatic reset_dut();
        desc_t z;
        @(negedge Clk);
        Reset = 1'b1;
        pixel_clk = 1'b0;
        repeat (3) begin
            @(negedge Clk);
            chk("rst_rgb", {VGA_R, VGA_G, VGA_B}, 24'h0);
            chk("rst_sync", {VGA_HS, VGA_VS, VGA_BLANK_N, frame_start}, 4'b0000);
            chk("rst_addr", rom_addr, 8'd0);
        end
        Reset = 1'b0;
        for (int i = 0; i < 16; i++) pal_m[i] = 24'h0;
        vs_hist_m = 1'b1;
        started_m = 1'b0;
        sb.delete();
        z = '0;
        sb.push_back(z);
        sb.push_back(z);
    endtask

    task automatic pal_write(input logic [3:0] i, input logic [23:0] d);
        @(negedge Clk);
        pal_we = 1'b1; pal_idx = i; pal_data = d;
        pal_m[i] = d;
    endtask

    // One pixel period: pe on the first Clk edge, idle on the second.
    task automatic step(input int x, input int y, input logic hs, input logic vs, input logic blank,
                        input logic wr = 1'b0, input logic [3:0] widx = 4'd0,
                        input logic [23:0] wdata = 24'd0);
        desc_t d, e;
        int    ddx, ddy, exp_addr;
        logic  fs_exp;
        @(negedge Clk);
        chk("fs_width", frame_start, 1'b0);
        DrawX = 10'(x); DrawY = 10'(y); hs_in = hs; vs_in = vs; blank_in = blank;
        SpriteX = 10'(sx); SpriteY = 10'(sy);
        pixel_clk = 1'b1;
        pal_we = wr; pal_idx = widx; pal_data = wdata;
        ddx = x - sx;
        ddy = y - sy;
        d.hit   = (ddx >= 0 && ddx < 16 && ddy >= 0 && ddy < 16);
        exp_addr = d.hit ? (ddy * 16 + ddx) : 0;
        d.idx   = d.hit ? rom_fn(8'(exp_addr)) : 4'd0;
        d.blank = blank; d.hs = hs; d.vs = vs;
        fs_exp  = started_m && vs_hist_m && !vs;
        vs_hist_m = vs;
        started_m = 1'b1;
        sb.push_back(d);
        @(negedge Clk);
        pixel_clk = 1'b0;
        pal_we = 1'b0;
        chk("rom_addr", rom_addr, exp_addr);
        chk("frame_start", frame_start, fs_exp);
        if (frame_start) fs_count++;
        if (sb.size() == 3) begin
            e = sb.pop_front();
            chk("rgb", {VGA_R, VGA_G, VGA_B}, exp_rgb(e));
            chk("hs", VGA_HS, e.hs);
            chk("vs", VGA_VS, e.vs);
            chk("blank_n", VGA_BLANK_N, e.blank);
            if (!VGA_HS) hs_low++;
        end
        if (wr) pal_m[widx] = wdata;
    endtask

    initial begin
        reset_dut();

        // First visible pixel is background; earlier outputs stay blanked.
        sx = 100; sy = 50;
        for (int x = 0; x < 4; x++) step(x, 0, 1'b1, 1'b1, 1'b1);

        // Back-to-back palette writes, then a row across the sprite.
        pal_write(4'd3, 24'hFF0000);
        pal_write(4'd7, 24'h0000FF);
        @(negedge Clk);
        pal_we = 1'b0;
        for (int x = 98; x <= 117; x++) step(x, 50, 1'b1, 1'b1, 1'b1);

        // Transparent ROM address 5.
        zero_addr = 5;
        for (int x = 103; x <= 107; x++) step(x, 50, 1'b1, 1'b1, 1'b1);
        for (int x = 104; x <= 107; x++) step(x, 51, 1'b1, 1'b1, 1'b1);

        // Blank over the sprite.
        zero_addr = -1;
        for (int x = 108; x <= 112; x++) step(x, 52, 1'b1, 1'b1, 1'b0);

        // Palette write coinciding with the stage-2 read of pixel 100.
        step(100, 53, 1'b1, 1'b1, 1'b1);
        step(101, 53, 1'b1, 1'b1, 1'b1);
        step(102, 53, 1'b1, 1'b1, 1'b1, 1'b1, 4'd3, 24'h00FF00);
        step(103, 53, 1'b1, 1'b1, 1'b1);
        step(104, 53, 1'b1, 1'b1, 1'b1);

        // Horizontal sync pulse 656..751.
        hs_low = 0;
        for (int x = 600; x <= 753; x++)
            step(x, 10, !(x >= 656 && x <= 751), 1'b1, x < 640);
        chk("hs_low_count", hs_low, 96);

        // Sprite hanging off the right edge must not appear at the left.
        sx = 1020; sy = 50;
        for (int x = 0; x <= 13; x++) step(x, 50, 1'b1, 1'b1, 1'b1);

        // Three abbreviated frames.
        fs_count = 0;
        for (int f = 0; f < 3; f++) begin
            for (int x = 0; x < 4; x++) step(x, 490, 1'b1, 1'b1, 1'b0);
            for (int x = 4; x < 8; x++) step(x, 490, 1'b1, 1'b0, 1'b0);
        end
        chk("fs_count", fs_count, 3);

        // Mid-frame reset with vs already low: no pulse, blank held off for two pixels.
        sx = 100; sy = 50;
        reset_dut();
        fs_count = 0;
        for (int x = 100; x <= 106; x++) step(x, 50, 1'b1, 1'b0, 1'b1);
        chk("fs_after_reset", fs_count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
